// File: rtl/cacheline_adapter.sv
// Cache-line to memory-burst adapter: turns one 256-bit line transfer from the
// L1 controller into a 4-beat 64-bit burst on the physical-memory port.
module cacheline_adapter #(
   parameter int s_line  = 256,
   parameter int s_burst = 64,
   parameter int s_addr  = 32,
   parameter int beats   = s_line / s_burst
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [s_addr-1:0] address_i,
   input  logic              read_i,
   input  logic              write_i,
   input  logic [s_line-1:0] line_i,
   output logic [s_line-1:0] line_o,
   output logic              resp_o,
   input  logic [s_burst-1:0] burst_i,
   output logic [s_burst-1:0] burst_o,
   output logic [s_addr-1:0] address_o,
   output logic              read_o,
   output logic              write_o,
   input  logic              resp_i
);

   localparam int cw  = (beats > 1) ? $clog2(beats) : 1;
   localparam int off = $clog2(s_line / 8);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t                          state_q, state_d;
   logic [cw-1:0]                   cnt_q;
   logic [beats-1:0][s_burst-1:0]   buf_q;
   logic [s_addr-1:0]               addr_q;
   logic                            last;

   assign last = (cnt_q == cw'(beats - 1));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      read_o  = 1'b0;
      write_o = 1'b0;
      resp_o  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (read_i)       state_d = READ;
            else if (write_i) state_d = WRITE;
         end
         READ: begin
            read_o = 1'b1;
            if (resp_i && last) state_d = DONE;
         end
         WRITE: begin
            write_o = 1'b1;
            if (resp_i && last) state_d = DONE;
         end
         DONE: begin
            resp_o  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: the line buffer is reset too, because line_o must read as zero
   // straight out of reset; it is a register bank, not a RAM macro.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q  <= '0;
         buf_q  <= '0;
         addr_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (read_i || write_i) begin
                  addr_q <= {address_i[s_addr-1:off], {off{1'b0}}};
                  cnt_q  <= '0;
                  if (!read_i) buf_q <= line_i;
               end
            end
            READ: begin
               if (resp_i) begin
                  buf_q[cnt_q] <= burst_i;
                  cnt_q        <= last ? '0 : cnt_q + 1'b1;
               end
            end
            WRITE: begin
               if (resp_i) cnt_q <= last ? '0 : cnt_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign line_o    = buf_q;
   assign burst_o   = buf_q[cnt_q];
   assign address_o = addr_q;

endmodule

// File: tb/tb_cacheline_adapter.sv
// Self-checking bench for cacheline_adapter: directed and randomized fetches and
// writebacks compared against a beat-counting reference model.
module tb_cacheline_adapter;

   localparam int s_line  = 256;
   localparam int s_burst = 64;
   localparam int s_addr  = 32;
   localparam int beats   = 4;

   logic               clk = 1'b0;
   logic               rst;
   logic [s_addr-1:0]  address_i;
   logic               read_i, write_i;
   logic [s_line-1:0]  line_i, line_o;
   logic               resp_o;
   logic [s_burst-1:0] burst_i, burst_o;
   logic [s_addr-1:0]  address_o;
   logic               read_o, write_o, resp_i;

   int n_tests = 0;
   int n_fail  = 0;

   logic [s_addr-1:0] model_addr;
   logic [s_line-1:0] model_line;

   cacheline_adapter #(.s_line(s_line), .s_burst(s_burst), .s_addr(s_addr)) dut (
      .clk(clk), .rst(rst), .address_i(address_i), .read_i(read_i),
      .write_i(write_i), .line_i(line_i), .line_o(line_o), .resp_o(resp_o),
      .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
      .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [s_line-1:0] obs,
                        input logic [s_line-1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [s_line-1:0] rand_line();
      logic [s_line-1:0] v;
      for (int i = 0; i < s_line / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // Expected behaviour from the protocol rules: once requested, the memory
   // request stays up until four beats are accepted, then a single resp_o
   // cycle follows. Called #1 after a rising edge with the DUT in IDLE.
   // data is the line to write, or the line memory will return for a read.
   task automatic run_txn(input bit is_write, input logic [s_addr-1:0] addr,
                          input logic [s_line-1:0] data, input bit use_pat,
                          input logic [31:0] pat);
      logic [beats-1:0][s_burst-1:0] d;
      int k, stalls;
      bit r;
      d      = data;
      k      = 0;
      stalls = 0;
      check("idle_read_o",  read_o,  0);
      check("idle_write_o", write_o, 0);
      check("idle_resp_o",  resp_o,  0);
      check("idle_addr",    address_o, model_addr);
      read_i    = !is_write;
      write_i   = is_write;
      address_i = addr;
      line_i    = is_write ? data : rand_line();
      resp_i    = 1'($urandom_range(0, 1));
      burst_i   = {$urandom, $urandom};
      model_addr = addr & ~32'h1f;
      for (int c = 1; c < 64; c++) begin
         @(posedge clk); #1;
         if (is_write) line_i = '0;
         if (k == beats) begin
            check("done_resp_o",  resp_o,  1);
            check("done_read_o",  read_o,  0);
            check("done_write_o", write_o, 0);
            check("done_addr",    address_o, model_addr);
            check("done_line",    line_o,  data);
            model_line = data;
            read_i  = 1'b0;
            write_i = 1'b0;
            resp_i  = 1'b0;
            return;
         end
         check("burst_read_o",  read_o,  !is_write);
         check("burst_write_o", write_o, is_write);
         check("burst_resp_o",  resp_o,  0);
         check("burst_addr",    address_o, model_addr);
         if (is_write) check("burst_data", burst_o, d[k]);
         if (use_pat) r = pat[c-1];
         else         r = ($urandom_range(0, 2) != 0) || (stalls >= 3);
         stalls  = r ? 0 : stalls + 1;
         resp_i  = r;
         burst_i = r ? d[k] : {$urandom, $urandom};
         if (r) k++;
      end
      check("txn_timeout", k, beats + 1);
   endtask

   initial begin
      rst = 1'b1;
      address_i = '0; read_i = 1'b0; write_i = 1'b0; line_i = '0;
      burst_i = '0; resp_i = 1'b0;
      model_addr = '0;
      model_line = '0;
      #2 rst = 1'b0;
      #1;
      check("rst_read_o",  read_o,  0);
      check("rst_write_o", write_o, 0);
      check("rst_resp_o",  resp_o,  0);
      check("rst_line_o",  line_o,  0);
      check("rst_burst_o", burst_o, 0);
      check("rst_addr",    address_o, 0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      // Fetch without stalls.
      run_txn(1'b0, 32'h0000_1234,
              {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
               64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 1'b1, 32'hF);
      check("fetch_addr_1220", model_addr, 32'h0000_1220);
      @(posedge clk); #1;

      // Fetch with stall pattern 1,0,0,1,1,0,1.
      run_txn(1'b0, $urandom, rand_line(), 1'b1, 32'b1011001);
      @(posedge clk); #1;

      // Writeback from the latched line.
      run_txn(1'b1, 32'h0000_8040,
              {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
               64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}, 1'b1, 32'hF);
      @(posedge clk); #1;

      // Back-to-back writeback then fetch to a different address.
      run_txn(1'b1, 32'h0001_0000, rand_line(), 1'b0, 0);
      @(posedge clk); #1;
      run_txn(1'b0, 32'h0002_0020, rand_line(), 1'b0, 0);
      @(posedge clk); #1;

      // Idle noise: beats offered with no request.
      for (int i = 0; i < 5; i++) begin
         resp_i  = 1'b1;
         burst_i = {$urandom, $urandom};
         @(posedge clk); #1;
         check("noise_resp_o", resp_o,  0);
         check("noise_read_o", read_o,  0);
         check("noise_line",   line_o,  model_line);
      end
      resp_i = 1'b0;

      // Asynchronous reset during the second beat of a fetch.
      read_i = 1'b1; address_i = 32'h0000_0F00; resp_i = 1'b1;
      burst_i = {$urandom, $urandom};
      @(posedge clk); #1;
      check("mid_read_o_1", read_o, 1);
      @(posedge clk); #1;
      check("mid_read_o_2", read_o, 1);
      #2 rst = 1'b0;
      #1;
      check("mid_rst_read_o", read_o, 0);
      check("mid_rst_resp_o", resp_o, 0);
      check("mid_rst_line",   line_o, 0);
      check("mid_rst_addr",   address_o, 0);
      read_i = 1'b0; resp_i = 1'b0;
      @(posedge clk); #1;
      check("mid_rst_hold_resp_o", resp_o, 0);
      rst = 1'b1;
      model_addr = '0;
      model_line = '0;
      @(posedge clk); #1;
      run_txn(1'b0, $urandom, rand_line(), 1'b0, 0);
      @(posedge clk); #1;

      // Randomized mix of fetches and writebacks with random stalls.
      for (int i = 0; i < 12; i++) begin
         run_txn(1'($urandom_range(0, 1)), $urandom, rand_line(), 1'b0, 0);
         @(posedge clk); #1;
      end
      check("final_resp_o", resp_o, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cacheline_adapter.md
# cacheline_adapter

Bridges the L1 cache controller's single-transfer 256-bit line port to the 64-bit burst physical-memory port. Sits directly downstream of the cache controller. Its WRITEBACK/FETCH states drive `read_i`/`write_i`/`line_i`/`address_i` and wait on `resp_o`. The adapter performs one 4-beat memory burst per request, then acknowledges the cache.

## Interface
- `s_line`, default 256: cache line width in bits.
- `s_burst`, default 64: memory beat width in bits.
- `s_addr`, default 32: address width.
- `beats`, default `s_line/s_burst` = 4: beats per burst (derived).
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset; one clock, reset asynchronous and active-low.
- `address_i`  in  s_addr  line address from cache.
- `read_i`  in  1  cache requests line fetch; held until `resp_o`.
- `write_i`  in  1  cache requests line writeback; held until `resp_o`.
- `line_i`  in  s_line  writeback data.
- `line_o`  out  s_line  fetched line.
- `resp_o`  out  1  one-cycle completion pulse to cache.
- `burst_i`  in  s_burst  read beat from memory.
- `burst_o`  out  s_burst  write beat to memory.
- `address_o`  out  s_addr  burst base address.
- `read_o`  out  1  memory read request.
- `write_o`  out  1  memory write request.
- `resp_i`  in  1  memory beat handshake.

## Operation
- States: IDLE, READ, WRITE, DONE.
- Beat counter: `$clog2(beats)` bits (2).
- Line buffer: s_line bits. Address register: s_addr bits.
- IDLE:
  - `read_i` → READ; else `write_i` → WRITE.
  - `read_i` has priority if both are high. The cache never drives both.
  - On leaving IDLE:
    - address register ← `{address_i[s_addr-1:5], 5'b0}`, aligned to 32 bytes.
    - counter ← 0.
    - For a write, buffer ← `line_i`.
  - `resp_i` in IDLE is ignored.
- READ:
  - `read_o`=1.
  - Each cycle with `resp_i`=1: buffer[cnt*64 +: 64] ← `burst_i`, cnt++.
  - On the beat with cnt==beats-1 → DONE.
  - Cycles with `resp_i`=0 are stalls; state and counter hold.
- WRITE:
  - `write_o`=1, `burst_o` = buffer[cnt*64 +: 64].
  - Counter advances on `resp_i`=1.
  - Last beat → DONE.
- DONE:
  - `resp_o`=1 for exactly one cycle, then → IDLE unconditionally.
  - `read_i`/`write_i` are ignored in DONE, because the cache is still asserting them that cycle.
- Beat order: beat 0 = bits [63:0], ascending. No wrap-first ordering.
- `line_o` = buffer, continuously.
  - Valid in the DONE cycle.
  - Stable until the next READ overwrites it.
  - Contents after a WRITE equal the written line.
- `address_o` = address register; constant for the whole burst.
- `read_o`/`write_o`/`resp_o` decode from state only; no combinational path from inputs.

## Timing
- Reset (`rst`=0, asynchronous):
  - state=IDLE, cnt=0, buffer=0, address register=0.
  - Hence `read_o`=`write_o`=`resp_o`=0, `line_o`=0, `burst_o`=0, `address_o`=0.
- Reset mid-burst: `read_o`/`write_o` drop immediately and the burst is abandoned. No `resp_o` is produced.
- Request seen in cycle 0 → `read_o`/`write_o` high from cycle 1.
- With `resp_i` held high: beats occur in cycles 1–4, `resp_o` in cycle 5, IDLE in cycle 6.
  - Minimum turnaround is 6 cycles.
  - Each stall cycle adds one.
- `read_o`/`write_o` deassert in the cycle after the last beat (the DONE cycle).
- A new request can be accepted in the first IDLE cycle after DONE. The cache's next-state logic guarantees the cache has changed requests by then.
- Writeback followed by fetch: WRITE→DONE→IDLE→READ. `address_o` changes only on IDLE exit.

## Test plan
- Fetch, no stalls:
  - Stimulus: `read_i` @ `address_i`=0x0000_1234; `resp_i` high for 4 beats with `burst_i`=0x11…11, 0x22…22, 0x33…33, 0x44…44.
  - Required: `address_o`=0x0000_1220; `line_o`=0x44…44_33…33_22…22_11…11; `resp_o` one pulse in cycle 5.
- Fetch with stalls: `resp_i` pattern 1,0,0,1,1,0,1 → 4 beats captured in order, `resp_o` in cycle 8, `read_o` high cycles 1–7.
- Writeback:
  - Stimulus: `write_i`, `line_i`=0xDDDD…_CCCC…_BBBB…_AAAA…, `line_i` changed to 0 after cycle 0.
  - Required: `burst_o` = AAAA…, BBBB…, CCCC…, DDDD… on successive `resp_i` beats, from the latched line; `write_o` high 4 cycles; then `resp_o`.
- Back-to-back writeback then fetch to a different address:
  - `address_o` switches only after `resp_o`.
  - No overlap between `write_o` and `read_o`.
  - Second `resp_o` is ≥6 cycles after the first.
- Async reset asserted during beat 2 of a read: `read_o` low the same cycle, no `resp_o`; a subsequent fetch completes normally.
- Idle noise: `resp_i`=1 with no request → state stays IDLE, `resp_o` stays 0, `line_o` unchanged.
